// File: rtl/icmp_echo_engine_pkg.sv
// Shared definitions for the ICMP echo responder.
// Contents:
//   icmp_state_e         - responder FSM state encoding
//   ICMP_TYPE_ECHO_REQ   - ICMP type of an echo request
//   ICMP_TYPE_ECHO_REP   - ICMP type of an echo reply
//   ICMP_HDR_LEN         - ICMP echo header length in bytes
//   ones_fold16()        - one's-complement fold of a 32-bit sum into 16 bits
package icmp_echo_engine_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StRx,
      StCalc,
      StTx,
      StDrop
   } icmp_state_e;

   localparam logic [7:0]  ICMP_TYPE_ECHO_REQ = 8'h08;
   localparam logic [7:0]  ICMP_TYPE_ECHO_REP = 8'h00;
   localparam int unsigned ICMP_HDR_LEN       = 8;

   // Two end-around-carry folds are enough for any 32-bit input.
   function automatic logic [15:0] ones_fold16(input logic [31:0] val);
      logic [16:0] s;
      s = {1'b0, val[15:0]} + {1'b0, val[31:16]};
      s = {1'b0, s[15:0]} + {16'd0, s[16]};
      return s[15:0];
   endfunction

endpackage

// File: rtl/icmp_echo_engine_buf.sv
// Message buffer for the ICMP echo responder: BUF_DEPTH x 8 synchronous RAM with one
// write port and one read port. Read data appears one cycle after the address.
// Ports:
//   clk     - clock
//   wr_en   - write strobe
//   wr_addr - write address
//   wr_dat  - write byte
//   rd_addr - read address (sampled every cycle)
//   rd_dat  - read byte, one cycle after rd_addr
module icmp_echo_buf
   import icmp_echo_engine_pkg::*;
#(
   parameter int unsigned BUF_DEPTH = 256,
   parameter int unsigned ADDR_W    = 8
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_dat,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_dat
);

   logic [7:0] mem [BUF_DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_dat;
      end
      rd_dat <= mem[rd_addr];
   end

endmodule

// File: rtl/icmp_echo_engine.sv
// ICMP echo responder. Buffers an incoming ICMP message, validates it as an echo request
// and answers with an echo reply carrying a recomputed checksum and the original payload.
// Optional feature macro: ICMP_RX_CKSUM_CHK_EN - also drop requests whose received
// checksum does not verify.
// Ports:
//   sys_clk, sys_rst_n        - clock, asynchronous active-low reset
//   icmp_rx_ip_len/src_ip/src_mac - sender metadata, sampled on rx sop
//   icmp_rx_sop/eop/vld/dat   - incoming ICMP message byte stream (no back-pressure)
//   icmp_tx_rdy               - downstream ready
//   icmp_tx_ip_len/dst_ip/dst_mac - reply metadata
//   icmp_tx_sop/eop/vld/dat   - reply byte stream
//   icmp_busy                 - engine not idle
//   icmp_drop                 - one-cycle pulse per discarded message
module icmp_echo_engine
   import icmp_echo_engine_pkg::*;
#(
   parameter int unsigned BUF_DEPTH = 256,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned LEN_W     = 16
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [15:0] icmp_rx_ip_len,
   input  logic [31:0] icmp_rx_src_ip,
   input  logic [47:0] icmp_rx_src_mac,
   input  logic        icmp_rx_sop,
   input  logic        icmp_rx_eop,
   input  logic        icmp_rx_vld,
   input  logic [7:0]  icmp_rx_dat,
   input  logic        icmp_tx_rdy,
   output logic [15:0] icmp_tx_ip_len,
   output logic [31:0] icmp_tx_dst_ip,
   output logic [47:0] icmp_tx_dst_mac,
   output logic        icmp_tx_sop,
   output logic        icmp_tx_eop,
   output logic        icmp_tx_vld,
   output logic [7:0]  icmp_tx_dat,
   output logic        icmp_busy,
   output logic        icmp_drop
);

   localparam int unsigned ACC_W = LEN_W + 8;

   icmp_state_e       state_q;
   logic              calc2_q;
   logic [LEN_W-1:0]  cnt_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  idx_q;
   logic [7:0]        type_q;
   logic [7:0]        code_q;
   logic [ACC_W-1:0]  sum_q;
   logic [15:0]       fold_q;
   logic [15:0]       ck_q;
   logic [15:0]       meta_len_q;
   logic [31:0]       meta_ip_q;
   logic [47:0]       meta_mac_q;
   logic              tx_sop_q;
   logic              tx_eop_q;
   logic              tx_vld_q;
   logic [7:0]        tx_dat_q;
   logic              drop_q;
`ifdef ICMP_RX_CKSUM_CHK_EN
   logic [15:0]       old_ck_q;
`endif

   logic              start;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        rd_dat;
   logic [ACC_W-1:0]  sum_nxt;
   logic              len_bad;
   logic              hdr_bad;
   logic              ck_bad;
   logic              drop_err;
   logic              tx_acc;
   logic [LEN_W-1:0]  nidx;
   logic [7:0]        nbyte;

   // Receive side: buffer write, running payload sum and end-of-message validation.
   always_comb begin
      start   = icmp_rx_vld && icmp_rx_sop;
      wr_en   = 1'b0;
      wr_addr = '0;
      if (start && (state_q == StIdle || state_q == StDrop || state_q == StRx)) begin
         wr_en = 1'b1;
      end else if (state_q == StRx && icmp_rx_vld && cnt_q < LEN_W'(BUF_DEPTH)) begin
         wr_en   = 1'b1;
         wr_addr = ADDR_W'(cnt_q);
      end

      // Payload words are big-endian: even offsets supply the high byte.
      sum_nxt = sum_q;
      if (cnt_q >= LEN_W'(4) && cnt_q < LEN_W'(BUF_DEPTH)) begin
         sum_nxt = sum_q + (cnt_q[0] ? ACC_W'(icmp_rx_dat) : ACC_W'({icmp_rx_dat, 8'h00}));
      end

      // cnt_q is the index of the eop byte, so length = cnt_q + 1.
      len_bad = (cnt_q < LEN_W'(ICMP_HDR_LEN - 1)) || (cnt_q >= LEN_W'(BUF_DEPTH));
      hdr_bad = (type_q != ICMP_TYPE_ECHO_REQ) || (code_q != 8'h00);
`ifdef ICMP_RX_CKSUM_CHK_EN
      ck_bad  = ones_fold16(32'(sum_nxt) + 32'h0000_0800 + 32'(old_ck_q)) != 16'hFFFF;
`else
      ck_bad  = 1'b0;
`endif
      drop_err = len_bad || hdr_bad || ck_bad;
   end

   // Transmit side. The RAM is always addressed one byte ahead of the output register so
   // that rd_dat holds byte idx_q+1 whenever the output register advances.
   always_comb begin
      tx_acc  = tx_vld_q && icmp_tx_rdy;
      nidx    = tx_vld_q ? idx_q + LEN_W'(1) : '0;
      rd_addr = ADDR_W'(idx_q + (tx_acc ? LEN_W'(2) : LEN_W'(1)));
      if (nidx == LEN_W'(0)) begin
         nbyte = ICMP_TYPE_ECHO_REP;
      end else if (nidx == LEN_W'(1)) begin
         nbyte = 8'h00;
      end else if (nidx == LEN_W'(2)) begin
         nbyte = ck_q[15:8];
      end else if (nidx == LEN_W'(3)) begin
         nbyte = ck_q[7:0];
      end else begin
         nbyte = rd_dat;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= StIdle;
         calc2_q    <= 1'b0;
         cnt_q      <= '0;
         len_q      <= '0;
         idx_q      <= '0;
         type_q     <= '0;
         code_q     <= '0;
         sum_q      <= '0;
         fold_q     <= '0;
         ck_q       <= '0;
         meta_len_q <= '0;
         meta_ip_q  <= '0;
         meta_mac_q <= '0;
         tx_sop_q   <= 1'b0;
         tx_eop_q   <= 1'b0;
         tx_vld_q   <= 1'b0;
         tx_dat_q   <= '0;
         drop_q     <= 1'b0;
`ifdef ICMP_RX_CKSUM_CHK_EN
         old_ck_q   <= '0;
`endif
      end else begin
         drop_q <= 1'b0;
         // A fresh sop in IDLE, DROP or RX (re)starts capture from byte 0.
         if (start && (state_q == StIdle || state_q == StDrop || state_q == StRx)) begin
            meta_len_q <= icmp_rx_ip_len;
            meta_ip_q  <= icmp_rx_src_ip;
            meta_mac_q <= icmp_rx_src_mac;
            type_q     <= icmp_rx_dat;
            code_q     <= '0;
            sum_q      <= '0;
            cnt_q      <= LEN_W'(1);
`ifdef ICMP_RX_CKSUM_CHK_EN
            old_ck_q   <= '0;
`endif
         end
         unique case (state_q)
            StIdle, StDrop: begin
               drop_q <= (state_q == StDrop);
               if (start) begin
                  state_q <= icmp_rx_eop ? StDrop : StRx;
               end else begin
                  state_q <= StIdle;
               end
            end
            StRx: begin
               if (start) begin
                  drop_q  <= 1'b1;
                  state_q <= icmp_rx_eop ? StDrop : StRx;
               end else if (icmp_rx_vld) begin
                  if (cnt_q != LEN_W'(BUF_DEPTH)) begin
                     cnt_q <= cnt_q + LEN_W'(1);
                  end
                  if (cnt_q == LEN_W'(1)) begin
                     code_q <= icmp_rx_dat;
                  end
`ifdef ICMP_RX_CKSUM_CHK_EN
                  if (cnt_q == LEN_W'(2)) begin
                     old_ck_q[15:8] <= icmp_rx_dat;
                  end
                  if (cnt_q == LEN_W'(3)) begin
                     old_ck_q[7:0] <= icmp_rx_dat;
                  end
`endif
                  sum_q <= sum_nxt;
                  if (icmp_rx_eop) begin
                     len_q   <= cnt_q + LEN_W'(1);
                     calc2_q <= 1'b0;
                     state_q <= drop_err ? StDrop : StCalc;
                  end
               end
            end
            StCalc: begin
               drop_q <= start;
               if (!calc2_q) begin
                  fold_q  <= ones_fold16(32'(sum_q));
                  calc2_q <= 1'b1;
               end else begin
                  ck_q    <= ~fold_q;
                  state_q <= StTx;
               end
            end
            StTx: begin
               drop_q <= start;
               if (!tx_vld_q || tx_acc) begin
                  if (tx_vld_q && tx_eop_q) begin
                     tx_vld_q <= 1'b0;
                     tx_sop_q <= 1'b0;
                     tx_eop_q <= 1'b0;
                     state_q  <= StIdle;
                  end else begin
                     idx_q    <= nidx;
                     tx_dat_q <= nbyte;
                     tx_vld_q <= 1'b1;
                     tx_sop_q <= !tx_vld_q;
                     tx_eop_q <= (nidx == len_q - LEN_W'(1));
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   icmp_echo_buf #(
      .BUF_DEPTH (BUF_DEPTH),
      .ADDR_W    (ADDR_W)
   ) u_buf (
      .clk     (sys_clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_dat  (icmp_rx_dat),
      .rd_addr (rd_addr),
      .rd_dat  (rd_dat)
   );

   assign icmp_tx_ip_len  = meta_len_q;
   assign icmp_tx_dst_ip  = meta_ip_q;
   assign icmp_tx_dst_mac = meta_mac_q;
   assign icmp_tx_sop     = tx_sop_q;
   assign icmp_tx_eop     = tx_eop_q;
   assign icmp_tx_vld     = tx_vld_q;
   assign icmp_tx_dat     = tx_dat_q;
   assign icmp_busy       = (state_q != StIdle);
   assign icmp_drop       = drop_q;

endmodule
